// File: rtl/macro_pkg.sv
// Shared types and constants for the compute-in-memory macro sequencer.
package macro_pkg;

    localparam int N_IN_CH    = 32;
    localparam int N_TAP      = 9;
    localparam int N_OUT      = 64;
    localparam int N_PHASE    = 4;
    localparam int MACRO_O_DW = 8;

    // Index of the final chs_ps phase of a vector.
    localparam logic [1:0] LAST_PS = 2'(N_PHASE - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        CONV  = 2'd2,
        HOLD  = 2'd3
    } state_e;

    // One binary activation vector, [channel][tap].
    typedef logic [N_IN_CH-1:0][N_TAP-1:0] act_vec_t;

    // Full macro output at the default word width.
    typedef logic [N_OUT-1:0][MACRO_O_DW-1:0] out_arr_t;

endpackage

// File: rtl/macro_seq_wait.sv
// Loadable down-counter timing the ADC settle window; zero_o marks expiry.
module macro_seq_wait #(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;

    // Load on phase entry, otherwise count down and park at zero.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/macro_seq.sv
// Sequencer for one compute-in-memory macro: fetches activation vectors,
// steps the macro through its four chs_ps phases and streams each phase's
// outputs downstream with backpressure.
//
// state | meaning
// IDLE  | waiting for start; in_ready low
// FETCH | in_ready high, waiting for the next activation vector
// CONV  | ADC running on phase ps; m_adc pulses on the first cycle
// HOLD  | result presented on out_*, waiting for out_ready
module macro_seq
    import macro_pkg::*;
#(
    parameter int O_DW    = MACRO_O_DW,
    parameter int ADC_LAT = 2,
    parameter int CNT_W   = 16
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic                              start,
    input  logic [CNT_W-1:0]                  num_vec,
    output logic                              busy,
    output logic                              done,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [N_IN_CH-1:0][N_TAP-1:0]     in_data,
    output logic                              m_enable,
    output logic                              m_adc,
    output logic [1:0]                        m_chs_ps,
    output logic [N_IN_CH-1:0][N_TAP-1:0]     m_din,
    input  logic [N_OUT-1:0][O_DW-1:0]        m_dout,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [1:0]                        out_ps,
    output logic                              out_last,
    output logic [N_OUT-1:0][O_DW-1:0]        out_data
);

    // Counter is reloaded with ADC_LAT-1 so CONV lasts exactly ADC_LAT cycles.
    localparam int         WAIT_W    = 4;
    localparam logic [3:0] WAIT_INIT = 4'(ADC_LAT - 1);

    state_e                     state_q, state_d;
    logic [CNT_W-1:0]           num_vec_q, num_vec_d;
    logic [CNT_W-1:0]           vec_cnt_q, vec_cnt_d;
    logic [1:0]                 ps_q, ps_d;
    act_vec_t                   m_din_q, m_din_d;
    logic                       m_enable_q, m_enable_d;
    logic                       m_adc_q, m_adc_d;
    logic                       out_valid_q, out_valid_d;
    logic [1:0]                 out_ps_q, out_ps_d;
    logic                       out_last_q, out_last_d;
    logic [N_OUT-1:0][O_DW-1:0] out_data_q, out_data_d;
    logic                       done_q, done_d;
    logic                       wait_load;
    logic                       wait_zero;
    logic [CNT_W:0]             vec_nxt;

    // Extra bit keeps the last-vector compare exact at num_vec = 2^CNT_W - 1.
    assign vec_nxt = {1'b0, vec_cnt_q} + (CNT_W+1)'(1);

    macro_seq_wait #(
        .W(WAIT_W)
    ) u_wait (
        .clk_i      (clk),
        .rst_n_i    (rstn),
        .load_i     (wait_load),
        .load_val_i (WAIT_INIT),
        .zero_o     (wait_zero)
    );

    // State and output registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            num_vec_q   <= '0;
            vec_cnt_q   <= '0;
            ps_q        <= '0;
            m_din_q     <= '0;
            m_enable_q  <= 1'b0;
            m_adc_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_ps_q    <= '0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            num_vec_q   <= num_vec_d;
            vec_cnt_q   <= vec_cnt_d;
            ps_q        <= ps_d;
            m_din_q     <= m_din_d;
            m_enable_q  <= m_enable_d;
            m_adc_q     <= m_adc_d;
            out_valid_q <= out_valid_d;
            out_ps_q    <= out_ps_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
            done_q      <= done_d;
        end
    end

    // Next-state logic; m_adc and done are single-cycle pulses by default.
    always_comb begin
        state_d     = state_q;
        num_vec_d   = num_vec_q;
        vec_cnt_d   = vec_cnt_q;
        ps_d        = ps_q;
        m_din_d     = m_din_q;
        m_enable_d  = m_enable_q;
        m_adc_d     = 1'b0;
        out_valid_d = out_valid_q;
        out_ps_d    = out_ps_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        done_d      = 1'b0;
        wait_load   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (num_vec != '0) begin
                        num_vec_d = num_vec;
                        vec_cnt_d = '0;
                        state_d   = FETCH;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            FETCH: begin
                if (in_valid) begin
                    m_din_d    = in_data;
                    m_enable_d = 1'b1;
                    ps_d       = '0;
                    m_adc_d    = 1'b1;
                    wait_load  = 1'b1;
                    state_d    = CONV;
                end
            end
            CONV: begin
                if (wait_zero) begin
                    out_data_d  = m_dout;
                    out_valid_d = 1'b1;
                    out_ps_d    = ps_q;
                    out_last_d  = (ps_q == LAST_PS) && (vec_nxt == {1'b0, num_vec_q});
                    state_d     = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (ps_q != LAST_PS) begin
                        ps_d      = ps_q + 2'd1;
                        m_adc_d   = 1'b1;
                        wait_load = 1'b1;
                        state_d   = CONV;
                    end else if (vec_nxt < {1'b0, num_vec_q}) begin
                        vec_cnt_d  = vec_nxt[CNT_W-1:0];
                        m_enable_d = 1'b0;
                        state_d    = FETCH;
                    end else begin
                        m_enable_d = 1'b0;
                        done_d     = 1'b1;
                        state_d    = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy      = (state_q != IDLE);
    assign in_ready  = (state_q == FETCH);
    assign done      = done_q;
    assign m_enable  = m_enable_q;
    assign m_adc     = m_adc_q;
    assign m_chs_ps  = ps_q;
    assign m_din     = m_din_q;
    assign out_valid = out_valid_q;
    assign out_ps    = out_ps_q;
    assign out_last  = out_last_q;
    assign out_data  = out_data_q;

endmodule
